// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter sharing one PIPO load port between N_REQ sources.
// Emits a one-cycle load strobe, the captured word and a hold-off window.
module pipo_load_arbiter #(
  parameter int BUS_MSB     = 7,
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                           i_CLK,
  input  logic                           i_RST_N,
  input  logic [N_REQ-1:0]               i_REQ,
  input  logic [N_REQ*(BUS_MSB+1)-1:0]   i_DATA,
  output logic                           o_LOAD,
  output logic [BUS_MSB:0]               o_DATA,
  output logic [N_REQ-1:0]               o_ACK,
  output logic [$clog2(N_REQ)-1:0]       o_GNT_ID,
  output logic                           o_BUSY
);

  localparam int W  = BUS_MSB + 1;
  localparam int IW = $clog2(N_REQ);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic            load_q, load_d;
  logic [W-1:0]    data_q, data_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   win;
  logic [W-1:0]    win_data;

  // First set request at or above the pointer, wrapping modulo N_REQ.
  function automatic logic [IW-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IW-1:0]    ptr
  );
    logic found;
    int   j;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[IW'(j)]) begin
        rr_pick = IW'(j);
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    win      = rr_pick(i_REQ, ptr_q);
    win_data = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (win == IW'(r)) win_data = i_DATA[r*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    ack_d   = '0;
    data_d  = data_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|i_REQ) begin
          state_d = LOAD;
          load_d  = 1'b1;
          for (int r = 0; r < N_REQ; r++) begin
            ack_d[r] = (win == IW'(r));
          end
          data_d  = win_data;
          gnt_d   = win;
          busy_d  = 1'b1;
          ptr_d   = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
        end
      end
      LOAD: begin
        if (HOLD_CYCLES > 0) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYCLES - 1);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_LOAD   = load_q;
  assign o_DATA   = data_q;
  assign o_ACK    = ack_q;
  assign o_GNT_ID = gnt_q;
  assign o_BUSY   = busy_q;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: a 4-source/hold-3 and a 3-source/hold-0
// instance checked every cycle against a grant-time reference model.
module tb_pipo_load_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req_a;
  logic [31:0] data_a;
  logic        a_load;
  logic [7:0]  a_data;
  logic [3:0]  a_ack;
  logic [1:0]  a_gnt;
  logic        a_busy;

  logic [2:0]  req_b;
  logic [23:0] data_b;
  logic        b_load;
  logic [7:0]  b_data;
  logic [2:0]  b_ack;
  logic [1:0]  b_gnt;
  logic        b_busy;

  logic [7:0]  da [4];
  logic [7:0]  db [3];

  pipo_load_arbiter #(
    .BUS_MSB(7), .N_REQ(4), .HOLD_CYCLES(3)
  ) dut_a (
    .i_CLK(clk), .i_RST_N(rst_n), .i_REQ(req_a), .i_DATA(data_a),
    .o_LOAD(a_load), .o_DATA(a_data), .o_ACK(a_ack),
    .o_GNT_ID(a_gnt), .o_BUSY(a_busy)
  );

  pipo_load_arbiter #(
    .BUS_MSB(7), .N_REQ(3), .HOLD_CYCLES(0)
  ) dut_b (
    .i_CLK(clk), .i_RST_N(rst_n), .i_REQ(req_b), .i_DATA(data_b),
    .o_LOAD(b_load), .o_DATA(b_data), .o_ACK(b_ack),
    .o_GNT_ID(b_gnt), .o_BUSY(b_busy)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int e      = 0;

  // Reference: a grant at edge g loads at g, is busy through g+H,
  // and the next grant may happen no earlier than g+H+2.
  int m_load [2];
  int m_ack  [2];
  int m_data [2];
  int m_gnt  [2];
  int m_busy [2];
  int m_ptr  [2];
  int m_g    [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h",
             tag, e, obs, exp);
    end
  endtask

  task automatic model_reset(input int n);
    m_load[n] = 0; m_ack[n] = 0; m_data[n] = 0;
    m_gnt[n]  = 0; m_busy[n] = 0; m_ptr[n] = 0;
    m_g[n]    = -1000;
  endtask

  task automatic model_step(input int n, input int nr, input int h,
                            input int req, input logic [31:0] pk);
    int w;
    bit found;
    if (!rst_n) begin
      model_reset(n);
      return;
    end
    m_load[n] = 0;
    m_ack[n]  = 0;
    if ((e - m_g[n] >= h + 2) && req != 0) begin
      found = 0;
      w = 0;
      for (int i = 0; i < nr; i++) begin
        int j;
        j = (m_ptr[n] + i) % nr;
        if (!found && ((req >> j) & 1) == 1) begin
          w = j;
          found = 1;
        end
      end
      m_load[n] = 1;
      m_ack[n]  = 1 << w;
      m_data[n] = int'((pk >> (8 * w)) & 32'hFF);
      m_gnt[n]  = w;
      m_ptr[n]  = (w + 1) % nr;
      m_g[n]    = e;
    end
    m_busy[n] = (e - m_g[n] <= h) ? 1 : 0;
  endtask

  task automatic tick();
    data_a = {da[3], da[2], da[1], da[0]};
    data_b = {db[2], db[1], db[0]};
    @(posedge clk);
    e++;
    model_step(0, 4, 3, int'(req_a), data_a);
    model_step(1, 3, 0, int'(req_b), {8'h00, data_b});
    #1;
    chk("a_load", {31'b0, a_load}, m_load[0]);
    chk("a_ack",  {28'b0, a_ack},  m_ack[0]);
    chk("a_data", {24'b0, a_data}, m_data[0]);
    chk("a_gnt",  {30'b0, a_gnt},  m_gnt[0]);
    chk("a_busy", {31'b0, a_busy}, m_busy[0]);
    chk("b_load", {31'b0, b_load}, m_load[1]);
    chk("b_ack",  {29'b0, b_ack},  m_ack[1]);
    chk("b_data", {24'b0, b_data}, m_data[1]);
    chk("b_gnt",  {30'b0, b_gnt},  m_gnt[1]);
    chk("b_busy", {31'b0, b_busy}, m_busy[1]);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req_a = 4'b1111;
    req_b = 3'b111;
    for (int i = 0; i < 4; i++) da[i] = 8'h00;
    for (int i = 0; i < 3; i++) db[i] = 8'h00;
    model_reset(0);
    model_reset(1);

    // reset with every request raised
    tick();
    tick();
    rst_n = 1'b1;
    req_a = 4'b0000;
    req_b = 3'b000;
    tick();

    // single request from source 1
    da[1] = 8'hA5;
    req_a = 4'b0010;
    tick();
    chk("single_data", {24'b0, a_data}, 32'hA5);
    chk("single_gnt",  {30'b0, a_gnt},  32'd1);
    req_a = 4'b0000;
    for (int i = 0; i < 6; i++) tick();
    chk("single_hold_data", {24'b0, a_data}, 32'hA5);

    // fairness from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    da[0] = 8'h11; da[1] = 8'h22; da[2] = 8'h33; da[3] = 8'h44;
    req_a = 4'b1111;
    for (int i = 0; i < 20; i++) tick();

    // after the grant to 3, source 0 must win over 3
    req_a = 4'b1001;
    da[0] = 8'h5A;
    n = 0;
    while (m_load[0] == 0 && n < 20) begin
      tick();
      n++;
    end
    chk("wrap_gnt", {30'b0, a_gnt}, 32'd0);
    da[0] = 8'hFF;
    req_a = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    chk("capture_data", {24'b0, a_data}, 32'h5A);

    // reset during the hold window
    req_a = 4'b0011;
    n = 0;
    while (m_load[0] == 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", {30'b0, a_gnt}, 32'd0);
    chk("post_rst_load", {31'b0, a_load}, 32'd1);
    req_a = 4'b0000;

    // hold-off 0, three sources, top source held
    db[2] = 8'hC3;
    req_b = 3'b100;
    for (int i = 0; i < 8; i++) tick();
    req_b = 3'b101;
    db[0] = 8'h3C;
    for (int i = 0; i < 8; i++) tick();

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      req_a = 4'($urandom_range(0, 15));
      req_b = 3'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) da[k] = 8'($urandom);
      for (int k = 0; k < 3; k++) db[k] = 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipo_load_arbiter.md
Name: pipo_load_arbiter

Overview:
- Shares one PIPO load port between N_REQ requesters using round-robin arbitration.
- Generates a single-cycle load strobe and the muxed data word for the downstream PIPO register.
- Acknowledges the winning requester and enforces a minimum hold-off between consecutive loads.
- Sits between user inputs (switch banks, button-driven sources) and the shared PIPO register.

Parameters:
- BUS_MSB, 7: MSB index of the data word; word width is BUS_MSB+1.
- N_REQ, 4: number of requesters; must be at least 2.
- HOLD_CYCLES, 3: idle cycles forced after each load before the next grant; 0 is legal.

Ports:
- i_CLK  in  1  system clock; all logic on the rising edge.
- i_RST_N  in  1  synchronous active-low reset.
- i_REQ  in  N_REQ  level request per requester.
- i_DATA  in  N_REQ*(BUS_MSB+1)  packed words; requester r occupies bits [r*(BUS_MSB+1) +: BUS_MSB+1].
- o_LOAD  out  1  one-cycle load strobe; drives the PIPO load enable.
- o_DATA  out  BUS_MSB+1  data word to the PIPO; held between loads.
- o_ACK  out  N_REQ  one-hot, one-cycle acknowledge to the winner; asserted together with o_LOAD.
- o_GNT_ID  out  $clog2(N_REQ)  index of the last winner; held.
- o_BUSY  out  1  high during LOAD and HOLD.

Behaviour:
- Clocking and reset: one clock (i_CLK). Reset is synchronous and active-low (i_RST_N) and has priority over everything else.
- Reset values: state=IDLE, o_LOAD=0, o_DATA=0, o_ACK=0, o_GNT_ID=0, o_BUSY=0, priority pointer=0, hold counter=0.
- All outputs are registered; there are no combinational input-to-output paths.
- FSM states: IDLE, LOAD, HOLD.
- IDLE, i_REQ==0: stay in IDLE; all outputs hold, strobes stay 0.
- IDLE, i_REQ!=0 at edge k: the winner is the first set bit at or above the pointer, searching upward and wrapping modulo N_REQ.
- Registered effect of that edge k:
  - state=LOAD, o_LOAD=1, o_ACK=one-hot(winner);
  - o_DATA=winner's i_DATA slice, captured at edge k;
  - o_GNT_ID=winner, o_BUSY=1;
  - pointer=(winner+1) mod N_REQ.
- LOAD lasts exactly one cycle. At edge k+1, o_LOAD=0 and o_ACK=0.
  - If HOLD_CYCLES>0: go to HOLD with the counter loaded to HOLD_CYCLES-1; o_BUSY stays 1.
  - If HOLD_CYCLES==0: go to IDLE and o_BUSY=0.
- HOLD: the counter decrements each cycle. The state leaves for IDLE, with o_BUSY=0, on the edge where the counter equals 0. HOLD therefore lasts exactly HOLD_CYCLES cycles.
- Load spacing: the earliest next grant is edge k+2+HOLD_CYCLES, so the minimum spacing between o_LOAD pulses is HOLD_CYCLES+2 cycles.
- Requests are level-sensitive and must be held until o_ACK. A request dropped before it is granted is treated as withdrawn, with no memory of it.
- i_REQ and i_DATA are ignored during LOAD and HOLD. Changes to i_DATA after edge k do not affect o_DATA.
- Simultaneous requests are resolved purely by the round-robin pointer. No requester can be granted twice while another requester holds its request continuously.
- Reset asserted in LOAD or HOLD: after that edge, all reset values apply, the in-flight load strobe is cut, and the pointer returns to 0.
- Width rule: o_GNT_ID width is $clog2(N_REQ). Pointer arithmetic wraps modulo N_REQ, including non-power-of-two N_REQ (e.g. 3 requesters: pointer goes 2→0).

Test Plan:
1. Reset (N_REQ=4, HOLD_CYCLES=3): hold i_RST_N=0 for 2 cycles with i_REQ=4'b1111 → all outputs 0 and no o_LOAD.
2. Single request: i_REQ=4'b0010, slice1=8'hA5 → o_LOAD=1 for exactly 1 cycle with o_DATA=8'hA5, o_ACK=4'b0010, o_GNT_ID=1. o_BUSY high for 4 cycles, then 0. o_DATA remains A5 afterwards.
3. Fairness: i_REQ=4'b1111 held continuously → grants in order 0,1,2,3,0, with o_LOAD pulses spaced exactly 5 cycles apart. Slices 11,22,33,44 appear on o_DATA in that order.
4. Wrap and data capture: after a grant to 3, set i_REQ=4'b1001 → grant 0, not 3. Change slice0 from 8'h5A to 8'hFF during LOAD → o_DATA stays 8'h5A.
5. Reset mid-HOLD: assert i_RST_N=0 for 1 cycle during HOLD → outputs return to reset values. Then i_REQ=4'b0011 → grant 0 on the first IDLE edge.
6. HOLD_CYCLES=0 with N_REQ=3 and i_REQ=3'b100 held → o_LOAD every 2 cycles, o_GNT_ID=2 each time, and the pointer wraps to 0.
